// File: rtl/env_adsr_if.sv
// env_adsr_if -- control/status bundle between a note sequencer and the
// ADSR envelope generator. The sequencer is the master, env_adsr the slave.
interface env_adsr_if;
   logic        tick;
   logic        gate;
   logic [15:0] attack_step;
   logic [15:0] decay_step;
   logic [15:0] sustain_level;
   logic [15:0] release_step;
   logic [15:0] env;
   logic        busy;
   logic        done;

   modport master (
      output tick, gate, attack_step, decay_step, sustain_level, release_step,
      input  env, busy, done
   );

   modport slave (
      input  tick, gate, attack_step, decay_step, sustain_level, release_step,
      output env, busy, done
   );
endinterface

// File: rtl/env_adsr.sv
// env_adsr -- ADSR envelope generator, Q2.14 unsigned level 0..MAXL.
// Each tick advances the envelope one step; gate edges move between phases.
// Optional macro ENV_RETRIG_HARD_EN: a gate rise while a note is still
// sounding restarts the attack from zero instead of from the current level.
module env_adsr #(
   parameter logic [15:0] MAXL = 16'h4000
) (
   input  logic       clk,
   input  logic       reset,
   env_adsr_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE
   } state_t;

   localparam logic [16:0] MAXL17 = {1'b0, MAXL};

   state_t      state_q, state_d;
   logic [15:0] level_q, level_d;
   logic        gate_q, gate_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        rise, fall;
   logic [15:0] sus_lvl;
   logic [16:0] att_sum, dec_lim;

   assign rise    = bus.gate & ~gate_q;
   assign fall    = ~bus.gate & gate_q;
   assign gate_d  = bus.gate;
   // Sustain above full scale would let the envelope exceed MAXL.
   assign sus_lvl = (bus.sustain_level > MAXL) ? MAXL : bus.sustain_level;
   // 17-bit sums so neither the attack add nor the decay limit can wrap.
   assign att_sum = {1'b0, level_q} + {1'b0, bus.attack_step};
   assign dec_lim = {1'b0, sus_lvl} + {1'b0, bus.decay_step};

   // Next-state and level computation; gate edges take priority over tick.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) state_d = S_ATTACK;
         end
         S_ATTACK, S_DECAY, S_SUSTAIN: begin
            if (fall) begin
               state_d = S_RELEASE;
`ifdef ENV_RETRIG_HARD_EN
            end else if (rise) begin
               level_d = 16'h0000;
               state_d = S_ATTACK;
`endif
            end else if (state_q == S_SUSTAIN) begin
               level_d = sus_lvl;
            end else if (bus.tick && state_q == S_ATTACK) begin
               if (bus.attack_step == 16'h0000 || att_sum >= MAXL17) begin
                  level_d = MAXL;
                  state_d = S_DECAY;
               end else begin
                  level_d = att_sum[15:0];
               end
            end else if (bus.tick) begin
               if (bus.decay_step == 16'h0000 || {1'b0, level_q} <= dec_lim) begin
                  level_d = sus_lvl;
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = level_q - bus.decay_step;
               end
            end
         end
         S_RELEASE: begin
            if (rise) begin
`ifdef ENV_RETRIG_HARD_EN
               level_d = 16'h0000;
`endif
               state_d = S_ATTACK;
            end else if (bus.tick) begin
               if (bus.release_step == 16'h0000 || level_q <= bus.release_step) begin
                  level_d = 16'h0000;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  level_d = level_q - bus.release_step;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            level_d = 16'h0000;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, level and registered status outputs; reset abandons any note.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= 16'h0000;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         gate_q  <= gate_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.env  = level_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_env_adsr.sv
// tb_env_adsr -- vector/scoreboard bench for env_adsr.
// Each vector gives the inputs held across one clock edge and the env/busy/
// done values expected just after that edge.
module tb_env_adsr;

   logic clk = 1'b0;
   logic reset;
   env_adsr_if bus ();

   env_adsr #(.MAXL(16'h4000)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        gate;
      logic        tick;
      logic [15:0] a, d, s, r;
      logic [15:0] e;
      logic        b;
      logic        dn;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] e;
      logic        b;
      logic        dn;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input logic rst, input logic g, input logic t,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic [15:0] s, input logic [15:0] r,
                               input logic [15:0] e, input logic b,
                               input logic dn, input string name);
      vec_t v;
      v.rst = rst; v.gate = g; v.tick = t;
      v.a = a; v.d = d; v.s = s; v.r = r;
      v.e = e; v.b = b; v.dn = dn; v.name = name;
      return v;
   endfunction

   // Drive one vector, queue its expectation, then check after the edge.
   task automatic apply(input vec_t v);
      exp_t x;
      @(negedge clk);
      reset             = v.rst;
      bus.gate          = v.gate;
      bus.tick          = v.tick;
      bus.attack_step   = v.a;
      bus.decay_step    = v.d;
      bus.sustain_level = v.s;
      bus.release_step  = v.r;
      x.e = v.e; x.b = v.b; x.dn = v.dn; x.name = v.name;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      n_run++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         x = sb_q.pop_front();
         if (bus.env !== x.e || bus.busy !== x.b || bus.done !== x.dn) begin
            n_fail++;
            $display("FAIL %s: got env=%h busy=%b done=%b, want env=%h busy=%b done=%b",
                     x.name, bus.env, bus.busy, bus.done, x.e, x.b, x.dn);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; bus.gate = 1'b0; bus.tick = 1'b0;
      bus.attack_step = '0; bus.decay_step = '0;
      bus.sustain_level = '0; bus.release_step = '0;

      // Basic ADSR cycle, live sustain tracking, release to done.
      tbl.push_back(mk(1,0,0,16'h1000,16'h0800,16'h2000,16'h0800,16'h0000,0,0,"reset"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h0000,1,0,"rise"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h1000,1,0,"att1"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h2000,1,0,"att2"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h3000,1,0,"att3"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h4000,1,0,"att4"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h3800,1,0,"dec1"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h3000,1,0,"dec2"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h2800,1,0,"dec3"));
      tbl.push_back(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h2000,1,0,"dec4"));
      tbl.push_back(mk(0,1,0,16'h1000,16'h0800,16'h2400,16'h0800,16'h2400,1,0,"sus_track"));
      tbl.push_back(mk(0,1,0,16'h1000,16'h0800,16'h2000,16'h0800,16'h2000,1,0,"sus_back"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h2000,1,0,"fall"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h1800,1,0,"rel1"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h1000,1,0,"rel2"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h0800,1,0,"rel3"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h0000,0,1,"rel4_done"));
      tbl.push_back(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h0800,16'h0000,0,0,"idle_tick"));
      // Attack clamp, sustain clamp, instant release.
      tbl.push_back(mk(0,1,1,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h0000,1,0,"c_rise"));
      tbl.push_back(mk(0,1,1,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h3000,1,0,"c_att1"));
      tbl.push_back(mk(0,1,1,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h4000,1,0,"c_clamp"));
      tbl.push_back(mk(0,1,1,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h4000,1,0,"c_dec"));
      tbl.push_back(mk(0,1,0,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h4000,1,0,"c_sus"));
      tbl.push_back(mk(0,0,0,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h4000,1,0,"c_fall"));
      tbl.push_back(mk(0,0,1,16'h3000,16'h0800,16'hFFFF,16'h0000,16'h0000,0,1,"c_rel0"));
      // Instant attack and decay.
      tbl.push_back(mk(0,1,0,16'h0000,16'h0000,16'h1000,16'h0800,16'h0000,1,0,"i_rise"));
      tbl.push_back(mk(0,1,1,16'h0000,16'h0000,16'h1000,16'h0800,16'h4000,1,0,"i_att"));
      tbl.push_back(mk(0,1,1,16'h0000,16'h0000,16'h1000,16'h0800,16'h1000,1,0,"i_dec"));
      tbl.push_back(mk(0,0,1,16'h0000,16'h0000,16'h1000,16'h0800,16'h1000,1,0,"i_fall"));
      tbl.push_back(mk(0,0,1,16'h0000,16'h0000,16'h1000,16'h0800,16'h0800,1,0,"i_rel1"));
      tbl.push_back(mk(0,0,1,16'h0000,16'h0000,16'h1000,16'h0800,16'h0000,0,1,"i_rel2"));
      foreach (tbl[i]) apply(tbl[i]);

      // Fall coincident with tick in ATTACK, then a release step, then retrigger.
      apply(mk(1,0,0,16'h1000,16'h0800,16'h2000,16'h1000,16'h0000,0,0,"f_reset"));
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h0000,1,0,"f_rise"));
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h1000,1,0,"f_att1"));
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h2000,1,0,"f_att2"));
      apply(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h2000,1,0,"f_fall_tick"));
      apply(mk(0,0,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h1000,1,0,"f_rel1"));
`ifdef ENV_RETRIG_HARD_EN
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h0000,1,0,"retrig_hard"));
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h1000,1,0,"retrig_att"));
`else
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h1000,1,0,"retrig_legato"));
      apply(mk(0,1,1,16'h1000,16'h0800,16'h2000,16'h1000,16'h2000,1,0,"retrig_att"));
`endif

      // Reset in DECAY with gate held: no done, then a fresh attack.
      apply(mk(1,0,0,16'h2000,16'h0800,16'h1000,16'h0800,16'h0000,0,0,"r_reset"));
      apply(mk(0,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h0000,1,0,"r_rise"));
      apply(mk(0,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h2000,1,0,"r_att1"));
      apply(mk(0,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h4000,1,0,"r_att2"));
      apply(mk(0,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h3800,1,0,"r_dec1"));
      apply(mk(1,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h0000,0,0,"r_mid_reset"));
      apply(mk(0,1,0,16'h2000,16'h0800,16'h1000,16'h0800,16'h0000,1,0,"r_rise_after"));
      apply(mk(0,1,1,16'h2000,16'h0800,16'h1000,16'h0800,16'h2000,1,0,"r_att_again"));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/env_adsr.md
ENV_ADSR -- requirements
Module: env_adsr

Interface
REQ-001 SHALL have parameter MAXL, default 16'h4000, meaning full-scale envelope level (+1.0 in Q2.14).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-cycle strobe; each tick advances the envelope one step.
REQ-005 SHALL have port gate  input  1  note gate from the sequencer; high = note held.
REQ-006 SHALL have port attack_step  input  16  level increment per tick in ATTACK; 0 = instant.
REQ-007 SHALL have port decay_step  input  16  level decrement per tick in DECAY; 0 = instant.
REQ-008 SHALL have port sustain_level  input  16  SUSTAIN target; values above MAXL are clamped to MAXL.
REQ-009 SHALL have port release_step  input  16  level decrement per tick in RELEASE; 0 = instant.
REQ-010 SHALL have port env  output  16  registered envelope level, unsigned, 0..MAXL, Q2.14; drives the oscillator env input.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when RELEASE reaches 0.

Function
REQ-013 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-014 SHALL register gate into gate_q each cycle; rise = gate & ~gate_q; fall = ~gate & gate_q.
REQ-015 SHALL move IDLE -> ATTACK on the edge where rise is sampled; env unchanged that cycle.
REQ-016 SHALL move ATTACK/DECAY/SUSTAIN -> RELEASE on the edge where fall is sampled, whether or not tick is high; no step applied that cycle.
REQ-017 SHALL, in ATTACK on tick: if level + attack_step >= MAXL or attack_step == 0, set level = MAXL and go to DECAY; else add attack_step.
REQ-018 SHALL, in DECAY on tick: if level <= sustain + decay_step or decay_step == 0, set level = sustain and go to SUSTAIN; else subtract decay_step.
REQ-019 SHALL, in SUSTAIN, set level = clamped sustain_level every cycle (live tracking, no tick needed).
REQ-020 SHALL, in RELEASE on tick: if level <= release_step or release_step == 0, set level = 0, go to IDLE, and assert done for exactly that next cycle; else subtract release_step.
REQ-021 SHALL compute all add/compare arithmetic in 17 bits so no wrap-around occurs; env never exceeds MAXL nor underflows 0.
REQ-022 SHALL ignore tick in IDLE; env stays 0.
REQ-023 SHALL treat a rise in RELEASE per the Configuration section.
REQ-024 SHALL give rise/fall priority over tick when both occur in one cycle.
REQ-025 SHALL present env, busy, done as registered outputs; env reflects a step one cycle after the tick is sampled.

Reset
REQ-026 SHALL, when reset is high at a rising clk edge, force state = IDLE, level/env = 0, gate_q = 0, busy = 0, done = 0.
REQ-027 SHALL, on reset mid-note, abandon the note with no done pulse; a gate already high after reset releases is seen as a rise.

Configuration
REQ-028 SHALL recognise macro ENV_RETRIG_HARD_EN.
REQ-029 SHALL, with ENV_RETRIG_HARD_EN defined, on rise in any non-IDLE state, set level = 0 and enter ATTACK.
REQ-030 SHALL, without ENV_RETRIG_HARD_EN, on rise in RELEASE, enter ATTACK from the current level (legato); a rise in other non-IDLE states cannot occur without a prior fall.

Verification
REQ-031 SHALL test: attack_step=16'h1000, decay_step=16'h0800, sustain=16'h2000, gate high, tick every cycle -> env 0x1000,0x2000,0x3000,0x4000 then 0x3800,0x3000,0x2800,0x2000, state SUSTAIN.
REQ-032 SHALL test: in SUSTAIN, gate low, release_step=16'h0800, ticks -> env falls 0x1800..0x0000 over 4 ticks, done pulses one cycle, busy drops.
REQ-033 SHALL test: attack_step=16'h3000 -> env 0x3000 then clamps to 0x4000 (not 0x6000); sustain_level=16'hFFFF -> SUSTAIN env 0x4000.
REQ-034 SHALL test: release at env=0x1000, gate rises -> with ENV_RETRIG_HARD_EN env restarts from 0; without it attack continues from 0x1000.
REQ-035 SHALL test: gate fall and tick in same cycle during ATTACK at 0x2000 -> state RELEASE, env stays 0x2000 that cycle.
REQ-036 SHALL test: reset asserted in DECAY -> next cycle env=0, busy=0, done=0; gate held high -> ATTACK entered after reset releases.
